// File: rtl/honzales_float_pipe.sv
// Elastic DEPTH-stage float pipeline with valid/ready handshakes, a per-beat
// sign/NaN transform applied on entry, and a saturating NaN counter.
module honzales_float_pipe #(
  parameter  int EXP_W  = 8,
  parameter  int FRAC_W = 23,
  parameter  int DEPTH  = 2,
  parameter  int CNT_W  = 16,
  localparam int W      = 1 + EXP_W + FRAC_W,
  localparam int OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [W-1:0]     io_in_bits,
  input  logic [1:0]       io_in_mode,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [W-1:0]     io_out_bits,
  output logic [OCC_W-1:0] io_occupancy,
  output logic [CNT_W-1:0] io_nan_count,
  input  logic             io_clear_count
);

  localparam logic [W-1:0] CANON_NAN =
    {1'b0, {EXP_W{1'b1}}, {FRAC_W{1'b0}}} | (W'(1) << (FRAC_W - 1));

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_NEGATE = 2'b01,
    MODE_ABS    = 2'b10,
    MODE_CANON  = 2'b11
  } mode_t;

  logic [W-1:0]     stage_data [1:DEPTH];
  logic [DEPTH:1]   stage_valid;
  logic [DEPTH+1:1] adv;
  logic [W-1:0]     prev_data  [1:DEPTH];
  logic [DEPTH:1]   prev_valid;
  logic [W-1:0]     transformed;
  logic             in_is_nan;
  logic             in_fire;

  assign in_is_nan = (&io_in_bits[W-2:FRAC_W]) && (|io_in_bits[FRAC_W-1:0]);
  assign in_fire   = io_in_valid && adv[1];

  always_comb begin
    transformed = io_in_bits;
    unique case (mode_t'(io_in_mode))
      MODE_PASS:   transformed = io_in_bits;
      MODE_NEGATE: transformed = {~io_in_bits[W-1], io_in_bits[W-2:0]};
      MODE_ABS:    transformed = {1'b0, io_in_bits[W-2:0]};
      MODE_CANON:  transformed = in_is_nan ? CANON_NAN : io_in_bits;
      default:     transformed = io_in_bits;
    endcase
  end

  // A stage may advance if it or any stage downstream of it holds a bubble,
  // or the consumer is taking the head beat this cycle.
  always_comb begin
    logic bubble;
    bubble         = io_out_ready;
    adv            = '0;
    adv[DEPTH + 1] = io_out_ready;
    for (int k = DEPTH; k >= 1; k--) begin
      bubble = bubble | ~stage_valid[k];
      adv[k] = bubble;
    end
  end

  always_comb begin
    prev_valid    = '0;
    prev_valid[1] = io_in_valid;
    prev_data[1]  = transformed;
    for (int k = 2; k <= DEPTH; k++) begin
      prev_valid[k] = stage_valid[k-1];
      prev_data[k]  = stage_data[k-1];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stage_valid <= '0;
    end else begin
      for (int k = 1; k <= DEPTH; k++) begin
        if (adv[k]) stage_valid[k] <= prev_valid[k];
      end
    end
  end

  // Payload registers carry no reset; only the valids define occupancy.
  always_ff @(posedge clock) begin
    for (int k = 1; k <= DEPTH; k++) begin
      if (adv[k] && prev_valid[k]) stage_data[k] <= prev_data[k];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_nan_count <= '0;
    end else if (io_clear_count) begin
      io_nan_count <= '0;
    end else if (in_fire && in_is_nan && (io_nan_count != {CNT_W{1'b1}})) begin
      io_nan_count <= io_nan_count + CNT_W'(1);
    end
  end

  always_comb begin
    io_occupancy = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      io_occupancy = io_occupancy + OCC_W'(stage_valid[k]);
    end
  end

  assign io_in_ready  = adv[1];
  assign io_out_valid = stage_valid[DEPTH];
  assign io_out_bits  = stage_data[DEPTH];

endmodule

// File: tb/tb_honzales_float_pipe.sv
// Scoreboard bench for honzales_float_pipe: directed vectors, a stall/drain
// stream, random handshakes, reset flush and counter saturation.
module tb_honzales_float_pipe;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_in_valid = 1'b0;
  logic        io_in_ready;
  logic [31:0] io_in_bits = '0;
  logic [1:0]  io_in_mode = '0;
  logic        io_out_valid;
  logic        io_out_ready = 1'b1;
  logic [31:0] io_out_bits;
  logic [1:0]  io_occupancy;
  logic [15:0] io_nan_count;
  logic        io_clear_count = 1'b0;

  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [31:0] s_in_bits = 32'h7F80_0001;
  logic [1:0]  s_in_mode = '0;
  logic        s_out_valid;
  logic [31:0] s_out_bits;
  logic [1:0]  s_occupancy;
  logic [3:0]  s_nan_count;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          in_flight = 0;
  int          nan_exp = 0;
  bit          mon_en = 0;
  bit          lat_check = 0;
  bit          sent_done = 0;
  bit          rand_done = 0;
  logic [31:0] exp_q[$];
  int          acc_cyc_q[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  honzales_float_pipe #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_bits(io_in_bits), .io_in_mode(io_in_mode),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_bits(io_out_bits), .io_occupancy(io_occupancy),
    .io_nan_count(io_nan_count), .io_clear_count(io_clear_count)
  );

  honzales_float_pipe #(.DEPTH(DEPTH), .CNT_W(4)) dut_sat (
    .clock(clock), .reset(reset),
    .io_in_valid(s_in_valid), .io_in_ready(s_in_ready),
    .io_in_bits(s_in_bits), .io_in_mode(s_in_mode),
    .io_out_valid(s_out_valid), .io_out_ready(1'b1),
    .io_out_bits(s_out_bits), .io_occupancy(s_occupancy),
    .io_nan_count(s_nan_count), .io_clear_count(1'b0)
  );

  function automatic bit is_nan(input logic [31:0] b);
    return (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  endfunction

  function automatic logic [31:0] model(input logic [31:0] b, input logic [1:0] m);
    case (m)
      2'b01:   return {~b[31], b[30:0]};
      2'b10:   return {1'b0, b[30:0]};
      2'b11:   return is_nan(b) ? 32'h7FC0_0000 : b;
      default: return b;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Called on a negedge; returns on the negedge after the beat was taken.
  task automatic applyStimulus(input logic [31:0] b, input logic [1:0] m, input logic [31:0] expv);
    int  waits;
    bit  taken;
    waits = 0;
    taken = 0;
    io_in_valid = 1'b1;
    io_in_bits  = b;
    io_in_mode  = m;
    forever begin
      #4;
      if (io_in_ready) begin
        taken = 1;
        break;
      end
      waits++;
      if (waits > 500) begin
        checkOutput("in_ready timeout", 64'(0), 64'(1));
        break;
      end
      @(negedge clock);
    end
    if (taken) begin
      exp_q.push_back(expv);
      acc_cyc_q.push_back(cyc);
      in_flight++;
      if (io_clear_count) nan_exp = 0;
      else if (is_nan(b)) nan_exp++;
    end
    @(negedge clock);
    io_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clock);
    if (exp_q.size() != 0) checkOutput("drain timeout", 64'(exp_q.size()), 64'(0));
  endtask

  // Monitor: occupancy mid-cycle, output compare just before each rising edge.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (mon_en) checkOutput("occupancy", 64'(io_occupancy), 64'(in_flight));
      #2;
      if (mon_en && io_out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected output", 64'(io_out_bits), 64'(0));
        end else begin
          checkOutput("out_bits", 64'(io_out_bits), 64'(exp_q[0]));
          if (io_out_ready) begin
            int acc;
            void'(exp_q.pop_front());
            acc = acc_cyc_q.pop_front();
            in_flight--;
            if (lat_check) checkOutput("latency", 64'(cyc - acc), 64'(DEPTH));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clock);
    checkOutput("reset out_valid", 64'(io_out_valid), 64'(0));
    checkOutput("reset occupancy", 64'(io_occupancy), 64'(0));
    checkOutput("reset nan_count", 64'(io_nan_count), 64'(0));
    checkOutput("reset sat nan_count", 64'(s_nan_count), 64'(0));
    reset = 1'b1;
    #1;
    checkOutput("in_ready after reset", 64'(io_in_ready), 64'(1));
    @(negedge clock);
    mon_en = 1;

    lat_check = 1;
    applyStimulus(32'h3F80_0000, 2'b00, 32'h3F80_0000);
    drain();
    applyStimulus(32'h4049_0FDB, 2'b01, 32'hC049_0FDB);
    applyStimulus(32'hC000_0000, 2'b10, 32'h4000_0000);
    drain();
    applyStimulus(32'h7F80_0001, 2'b11, 32'h7FC0_0000);
    drain();
    checkOutput("nan_count after snan", 64'(io_nan_count), 64'(1));
    applyStimulus(32'h7F80_0000, 2'b11, 32'h7F80_0000);
    drain();
    checkOutput("nan_count after inf", 64'(io_nan_count), 64'(1));
    applyStimulus(32'hFF80_0005, 2'b00, 32'hFF80_0005);
    applyStimulus(32'hFFC1_2345, 2'b11, 32'h7FC0_0000);
    applyStimulus(32'h8000_0000, 2'b01, 32'h0000_0000);
    drain();
    checkOutput("nan_count mixed modes", 64'(io_nan_count), 64'(3));
    lat_check = 0;

    io_out_ready = 1'b0;
    sent_done = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) applyStimulus(32'h4100_0000 + i, 2'b00, 32'h4100_0000 + i);
        sent_done = 1;
      end
      begin
        int n;
        repeat (6) @(negedge clock);
        #3;
        checkOutput("full occupancy", 64'(io_occupancy), 64'(DEPTH));
        checkOutput("full in_ready", 64'(io_in_ready), 64'(0));
        checkOutput("full out_bits held", 64'(io_out_bits), 64'(32'h4100_0000));
        @(negedge clock);
        io_out_ready = 1'b1;
        for (n = 0; n < 50 && (exp_q.size() != 0 || !sent_done); n++) @(negedge clock);
        checkOutput("drain cycles", 64'(n), 64'(10));
      end
    join

    rand_done = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [31:0] b;
          logic [1:0]  m;
          int          kind;
          kind = $urandom_range(0, 7);
          b = $urandom;
          if (kind < 2) b = {b[31], 8'hFF, (b[22:0] == 23'd0) ? 23'd1 : b[22:0]};
          else if (kind == 2) b = {b[31], 8'hFF, 23'd0};
          m = 2'($urandom_range(0, 3));
          repeat ($urandom_range(0, 2)) @(negedge clock);
          applyStimulus(b, m, model(b, m));
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(negedge clock);
          io_out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    @(negedge clock);
    io_out_ready = 1'b1;
    drain();
    checkOutput("nan_count after random", 64'(io_nan_count), 64'(nan_exp));

    io_clear_count = 1'b1;
    applyStimulus(32'h7F80_0123, 2'b00, 32'h7F80_0123);
    io_clear_count = 1'b0;
    drain();
    checkOutput("nan_count clear wins", 64'(io_nan_count), 64'(0));
    applyStimulus(32'h7FFF_FFFF, 2'b10, 32'h7FFF_FFFF);
    drain();
    checkOutput("nan_count after clear", 64'(io_nan_count), 64'(1));

    io_out_ready = 1'b0;
    applyStimulus(32'h7F80_0002, 2'b11, 32'h7FC0_0000);
    applyStimulus(32'h7F80_0003, 2'b11, 32'h7FC0_0000);
    reset = 1'b0;
    exp_q.delete();
    acc_cyc_q.delete();
    in_flight = 0;
    nan_exp = 0;
    #1;
    checkOutput("midreset out_valid", 64'(io_out_valid), 64'(0));
    checkOutput("midreset occupancy", 64'(io_occupancy), 64'(0));
    checkOutput("midreset nan_count", 64'(io_nan_count), 64'(0));
    @(negedge clock);
    reset = 1'b1;
    io_out_ready = 1'b1;
    repeat (6) @(negedge clock);
    checkOutput("no output after reset", 64'(io_out_valid), 64'(0));

    s_in_valid = 1'b1;
    repeat (10) @(negedge clock);
    checkOutput("sat count at 10", 64'(s_nan_count), 64'(10));
    repeat (10) @(negedge clock);
    s_in_valid = 1'b0;
    @(negedge clock);
    checkOutput("sat count saturates", 64'(s_nan_count), 64'(15));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
